// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention-score drain path.
// FP32 ordering is done on an unsigned "order key" so that the whole float
// line (including -0 < +0) compares with a single unsigned compare.
package attn_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_RUN  = 1'b1
    } drain_state_e;

    // Map an FP32 bit pattern to a key whose unsigned order matches float order.
    // Negative values are bit-inverted, positives get the sign bit forced high.
    // NaNs are not special-cased; they simply sort by their bit pattern.
    function automatic logic [31:0] fp32_order_key(input fp32_t value);
        return value[31] ? ~value : (value | 32'h8000_0000);
    endfunction

    // Larger of two FP32 values under the order key; ties keep the first.
    function automatic fp32_t fp32_max(input fp32_t a, input fp32_t b);
        return (fp32_order_key(b) > fp32_order_key(a)) ? b : a;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head (first-word fall-through).
// Push and pop may coincide, including when full: the pop frees the slot the
// push is written into.
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push;
    logic              do_pop;

    // Qualify requests: never pop empty, only push into a free (or freeing) slot.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage write; no reset needed because entries are only read once valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

    // A push into a full FIFO without a same-cycle pop would lose data.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/attention_score_row_drain.sv
// Drains the T x T attention-score buffer in row-major order, streams every
// score on a valid/ready port and emits one FP32 maximum per row.
// Reads are credit-limited: a request is only issued when the response FIFO
// is guaranteed a slot, so downstream backpressure can never drop a response.
module attention_score_row_drain #(
    parameter int T          = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int T_W       = (T <= 1) ? 1 : $clog2(T)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              score_re,
    output logic [T_W-1:0]    score_tq,
    output logic [T_W-1:0]    score_tk,
    input  logic [DATA_W-1:0] score_rdata,
    input  logic              score_rvalid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [T_W-1:0]    out_tq,
    output logic [T_W-1:0]    out_tk,
    output logic              out_last,
    output logic              rowmax_valid,
    output logic [T_W-1:0]    rowmax_tq,
    output logic [DATA_W-1:0] rowmax_data
);

    import attn_pkg::*;

    localparam int TOTAL = T * T;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);

    drain_state_e      state_reg, state_next;

    logic [T_W-1:0]    issue_tq_reg, issue_tk_reg;
    logic [CNT_W-1:0]  issue_count_reg;
    logic              score_re_reg;
    logic [T_W-1:0]    score_tq_reg, score_tk_reg;
    logic [FC_W-1:0]   outstanding_reg;

    logic [T_W-1:0]    out_tq_reg, out_tk_reg;
    logic [DATA_W-1:0] run_max_reg;
    logic [DATA_W-1:0] row_max_next;
    logic              rowmax_valid_reg;
    logic [T_W-1:0]    rowmax_tq_reg;
    logic [DATA_W-1:0] rowmax_data_reg;
    logic              done_reg;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FC_W-1:0]   fifo_count;

    logic [FC_W:0]     credit_used;
    logic              start_accept;
    logic              issue_fire;
    logic              resp_accept;
    logic              handshake;
    logic              issue_tk_last, issue_tq_last;
    logic              out_tk_last, out_tq_last, elem_last;

    // Response buffer; its occupancy feeds back into the issue credit check.
    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (resp_accept),
        .push_data (score_rdata),
        .pop       (handshake),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Control decode: start acceptance, credit check, handshake and index ends.
    always_comb begin
        credit_used   = {1'b0, outstanding_reg} + {1'b0, fifo_count};
        // A start coinciding with done is dropped so back-to-back pulses
        // cannot alias onto the completing sweep.
        start_accept  = (state_reg == DRAIN_IDLE) && start && !done_reg;
        issue_fire    = (state_reg == DRAIN_RUN)
                        && (issue_count_reg < CNT_W'(TOTAL))
                        && (credit_used < (FC_W + 1)'(FIFO_DEPTH));
        // Late responses after a reset are dropped: nothing is outstanding.
        resp_accept   = score_rvalid && (outstanding_reg != '0);
        handshake     = !fifo_empty && out_ready;
        issue_tk_last = (issue_tk_reg == T_W'(T - 1));
        issue_tq_last = (issue_tq_reg == T_W'(T - 1));
        out_tk_last   = (out_tk_reg == T_W'(T - 1));
        out_tq_last   = (out_tq_reg == T_W'(T - 1));
        elem_last     = out_tk_last && out_tq_last;
        row_max_next  = (out_tk_reg == '0) ? fifo_head : fp32_max(run_max_reg, fifo_head);
    end

    // FSM next state: IDLE -> RUN on start, RUN -> IDLE when the last element leaves.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DRAIN_IDLE: if (start_accept) state_next = DRAIN_RUN;
            DRAIN_RUN:  if (handshake && elem_last) state_next = DRAIN_IDLE;
            default:    state_next = DRAIN_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DRAIN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read-request issue: registered request outputs and row-major issue index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_tq_reg    <= '0;
            issue_tk_reg    <= '0;
            issue_count_reg <= '0;
            score_re_reg    <= 1'b0;
            score_tq_reg    <= '0;
            score_tk_reg    <= '0;
        end else begin
            score_re_reg <= issue_fire;
            if (start_accept) begin
                issue_tq_reg    <= '0;
                issue_tk_reg    <= '0;
                issue_count_reg <= '0;
            end else if (issue_fire) begin
                score_tq_reg    <= issue_tq_reg;
                score_tk_reg    <= issue_tk_reg;
                issue_count_reg <= issue_count_reg + 1'b1;
                if (issue_tk_last) begin
                    issue_tk_reg <= '0;
                    issue_tq_reg <= issue_tq_last ? '0 : issue_tq_reg + 1'b1;
                end else begin
                    issue_tk_reg <= issue_tk_reg + 1'b1;
                end
            end
        end
    end

    // Outstanding-request counter; an issue and a response in one cycle cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
        end else if (issue_fire && !resp_accept) begin
            outstanding_reg <= outstanding_reg + 1'b1;
        end else if (!issue_fire && resp_accept) begin
            outstanding_reg <= outstanding_reg - 1'b1;
        end
    end

    // Output index, advanced by each accepted stream element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tq_reg <= '0;
            out_tk_reg <= '0;
        end else if (start_accept) begin
            out_tq_reg <= '0;
            out_tk_reg <= '0;
        end else if (handshake) begin
            if (out_tk_last) begin
                out_tk_reg <= '0;
                out_tq_reg <= out_tq_last ? '0 : out_tq_reg + 1'b1;
            end else begin
                out_tk_reg <= out_tk_reg + 1'b1;
            end
        end
    end

    // Running row maximum, row-max pulse and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_reg      <= '0;
            rowmax_valid_reg <= 1'b0;
            rowmax_tq_reg    <= '0;
            rowmax_data_reg  <= '0;
            done_reg         <= 1'b0;
        end else begin
            rowmax_valid_reg <= handshake && out_tk_last;
            done_reg         <= handshake && elem_last;
            if (handshake) begin
                run_max_reg <= row_max_next;
            end
            if (handshake && out_tk_last) begin
                rowmax_tq_reg   <= out_tq_reg;
                rowmax_data_reg <= row_max_next;
            end
        end
    end

    // Consistency with the credit scheme: a response never lands on a full FIFO
    // unless the head is leaving in the same cycle.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(resp_accept && fifo_full && !handshake));

    assign busy         = (state_reg == DRAIN_RUN);
    assign done         = done_reg;
    assign score_re     = score_re_reg;
    assign score_tq     = score_tq_reg;
    assign score_tk     = score_tk_reg;
    assign out_valid    = !fifo_empty;
    assign out_data     = fifo_empty ? '0 : fifo_head;
    assign out_tq       = out_tq_reg;
    assign out_tk       = out_tk_reg;
    assign out_last     = !fifo_empty && elem_last;
    assign rowmax_valid = rowmax_valid_reg;
    assign rowmax_tq    = rowmax_tq_reg;
    assign rowmax_data  = rowmax_data_reg;

endmodule
